// File: rtl/ciphercore_pkg.sv
// Shared constants and types for the CipherCore receive path.
package ciphercore_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam int unsigned ERR_W = 3;
    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_CHK     = 3'd1;
    localparam logic [ERR_W-1:0] ERR_LEN     = 3'd2;
    localparam logic [ERR_W-1:0] ERR_LINE    = 3'd3;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/uart_frame_if.sv
// Byte input, frame handshake and status signals of the frame assembler.
interface uart_frame_if
    import ciphercore_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic [7:0]           rx_data;
    logic                 rx_done;
    logic                 rx_valid;
    logic [MAX_LEN*8-1:0] frame_data;
    logic [LW-1:0]        frame_len;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 err_pulse;
    logic [ERR_W-1:0]     err_code;
    logic                 overrun;

    modport master (
        input  rx_data, rx_done, rx_valid, frame_ready,
        output frame_data, frame_len, frame_valid, err_pulse, err_code, overrun
    );

    modport slave (
        output rx_data, rx_done, rx_valid, frame_ready,
        input  frame_data, frame_len, frame_valid, err_pulse, err_code, overrun
    );

endinterface

// File: rtl/uart_frame_assembler_timer.sv
// Inactivity timer: flags expiry after TIMEOUT_CYCLES-1 idle cycles since the last kick.
module inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    // cnt reads 0 in the first idle cycle after a kick, so expiry lands on idle cycle TIMEOUT_CYCLES-1
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable || kick) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A kick in the expiry cycle wins over the timeout
    assign expired = enable & ~kick & (cnt == LAST);

endmodule

// File: rtl/uart_frame_assembler.sv
// Parses SOF/LEN/payload/CHK byte frames and presents each good frame as one wide word.
module uart_frame_assembler
    import ciphercore_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    uart_frame_if.master bus
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t                   state;
    logic [MAX_LEN-1:0][7:0]  buf_q;
    logic [LW-1:0]            len;
    logic [LW-1:0]            idx;
    logic [7:0]               chk;
    logic                     frame_valid;
    logic                     err_pulse;
    logic [ERR_W-1:0]         err_code;
    logic                     overrun;

    logic                     good_c;
    logic                     line_err_c;
    logic                     in_frame_c;
    logic                     expired_c;
    logic                     err_c;
    logic [ERR_W-1:0]         err_code_c;

    assign good_c     = bus.rx_done & bus.rx_valid;
    assign line_err_c = bus.rx_done & ~bus.rx_valid;
    assign in_frame_c = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (in_frame_c),
        .kick   (bus.rx_done),
        .expired(expired_c)
    );

    // Error classification; a byte event always takes priority over expiry
    always_comb begin
        err_code_c = ERR_NONE;
        if (in_frame_c) begin
            if (line_err_c) begin
                err_code_c = ERR_LINE;
            end else if (good_c) begin
                if ((state == ST_LEN) && ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > MAX_LEN))) begin
                    err_code_c = ERR_LEN;
                end else if ((state == ST_CHK) && (bus.rx_data != chk)) begin
                    err_code_c = ERR_CHK;
                end
            end else if (expired_c) begin
                err_code_c = ERR_TIMEOUT;
            end
        end
        err_c = (err_code_c != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            buf_q       <= '0;
            len         <= '0;
            idx         <= '0;
            chk         <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
            overrun     <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            overrun   <= 1'b0;
            if (err_c) begin
                err_pulse <= 1'b1;
                err_code  <= err_code_c;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Clearing the buffer keeps bytes beyond len reading as zero
                        if (good_c && (bus.rx_data == SOF_BYTE)) begin
                            buf_q <= '0;
                            idx   <= '0;
                            chk   <= '0;
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (good_c) begin
                            len   <= LW'(bus.rx_data);
                            chk   <= bus.rx_data;
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (good_c) begin
                            buf_q[idx[IW-1:0]] <= bus.rx_data;
                            chk                <= chk ^ bus.rx_data;
                            idx                <= idx + LW'(1);
                            if (idx == (len - LW'(1))) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (good_c) begin
                            frame_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (bus.rx_done) begin
                            overrun <= 1'b1;
                        end
                        if (bus.frame_ready) begin
                            frame_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.frame_data  = buf_q;
    assign bus.frame_len   = len;
    assign bus.frame_valid = frame_valid;
    assign bus.err_pulse   = err_pulse;
    assign bus.err_code    = err_code;
    assign bus.overrun     = overrun;

endmodule
